// File: rtl/lsu_pkg.sv
// Shared definitions for the load-store unit: address map, access widths,
// blank seven-segment pattern and the load extension helper.
package lsu_pkg;

  // Region bases and the IO decode mask (each IO register owns one 4 KiB page)
  localparam logic [31:0] MEM_BASE    = 32'h0000_0000;
  localparam logic [31:0] IO_MASK     = 32'hFFFF_F000;
  localparam logic [31:0] LEDR_BASE   = 32'h1000_0000;
  localparam logic [31:0] LEDG_BASE   = 32'h1000_1000;
  localparam logic [31:0] HEX_LO_BASE = 32'h1000_2000;
  localparam logic [31:0] HEX_HI_BASE = 32'h1000_3000;
  localparam logic [31:0] LCD_BASE    = 32'h1000_4000;
  localparam logic [31:0] SW_BASE     = 32'h1001_0000;
  localparam logic [31:0] BTN_BASE    = 32'h1001_1000;

  // All segments off on an active-low display
  localparam logic [6:0] HEX_BLANK = 7'h7F;

  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } funct3_e;

  // True when addr falls in the IO page starting at base
  function automatic logic io_page_hit(input logic [31:0] addr, input logic [31:0] base);
    return (addr & IO_MASK) == base;
  endfunction

  // Sign/zero extension of low-aligned raw load data; unknown widths give 0
  function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [2:0] f3);
    logic [31:0] r;
    case (f3)
      LS_B:    r = {{24{raw[7]}}, raw[7:0]};
      LS_H:    r = {{16{raw[15]}}, raw[15:0]};
      LS_W:    r = raw;
      LS_BU:   r = {24'b0, raw[7:0]};
      LS_HU:   r = {16'b0, raw[15:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_io_if.sv
// Core/memory-side bus of the load-store unit.
// Access semantics: there is no valid/ready handshake. Every cycle the core
// presents one access (lsu_addr/st_data/lsu_wren/funct3); ld_data answers
// combinationally in the same cycle, stores commit on the next rising edge,
// and misaligned reports a rejected IO access one cycle later. The memory
// side is equally single-cycle: mem_rdata must be valid in the cycle that
// mem_addr/mem_mask are presented, and mem_wren writes at the next edge.
interface lsu_io_if #(parameter int MEM_AW = 11);
  logic [31:0]       lsu_addr;
  logic [31:0]       st_data;
  logic              lsu_wren;
  logic [2:0]        funct3;
  logic [31:0]       ld_data;
  logic              misaligned;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_mask;
  logic              mem_wren;
  logic [31:0]       mem_rdata;

  // Core datapath plus data memory: drives requests and read data
  modport master (
    output lsu_addr, st_data, lsu_wren, funct3, mem_rdata,
    input  ld_data, misaligned, mem_addr, mem_wdata, mem_mask, mem_wren
  );

  // Load-store unit
  modport slave (
    input  lsu_addr, st_data, lsu_wren, funct3, mem_rdata,
    output ld_data, misaligned, mem_addr, mem_wdata, mem_mask, mem_wren
  );
endinterface

// File: rtl/lsu_io_sync_ff.sv
// N-stage flop synchroniser for asynchronous board inputs, with a
// synchronous active-low clear.
module sync_ff #(
  parameter int W = 1,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [N];

  // Shift the input through N flops; clear empties the whole chain
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      for (int i = 0; i < N; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[N-1];

endmodule

// File: rtl/lsu_io.sv
// Load-store unit: address decode, memory byte-mask generation,
// memory-mapped output registers and load data extension.
module lsu_io
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 11,
  parameter int SYNC_N = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  lsu_io_if.slave     bus,
  output logic [31:0] io_ledr,
  output logic [31:0] io_ledg,
  output logic [6:0]  io_hex0,
  output logic [6:0]  io_hex1,
  output logic [6:0]  io_hex2,
  output logic [6:0]  io_hex3,
  output logic [6:0]  io_hex4,
  output logic [6:0]  io_hex5,
  output logic [6:0]  io_hex6,
  output logic [6:0]  io_hex7,
  output logic [31:0] io_lcd,
  input  logic [31:0] io_sw,
  input  logic [3:0]  io_btn
);

  logic [31:0] ledr, ledg, lcd;
  logic [6:0]  hex [8];
  logic [31:0] sw_sync;
  logic [3:0]  btn_sync;
  logic        misaligned_q;

  logic [3:0]  size_mask;
  logic        f3_valid;
  logic [1:0]  off;
  logic        hit_mem, hit_ledr, hit_ledg, hit_hex_lo, hit_hex_hi, hit_lcd, hit_sw, hit_btn;
  logic        hit_io, misalign, io_ok, io_we;
  logic [3:0]  lane_we;
  logic [31:0] wdata_sh, io_word, ld_raw;

  // Board inputs cross into the clock domain before any load can see them
  sync_ff #(.W(32), .N(SYNC_N)) u_sw_sync (
    .clk(i_clk), .clear_n(i_reset), .d(io_sw), .q(sw_sync)
  );
  sync_ff #(.W(4), .N(SYNC_N)) u_btn_sync (
    .clk(i_clk), .clear_n(i_reset), .d(io_btn), .q(btn_sync)
  );

  // Access width from funct3; unlisted encodings are rejected as invalid
  always_comb begin
    size_mask = 4'b0000;
    f3_valid  = 1'b1;
    case (bus.funct3)
      LS_B, LS_BU: size_mask = 4'b0001;
      LS_H, LS_HU: size_mask = 4'b0011;
      LS_W:        size_mask = 4'b1111;
      default:     f3_valid  = 1'b0;
    endcase
  end

  // Full 32-bit region decode
  assign off        = bus.lsu_addr[1:0];
  assign hit_mem    = ((bus.lsu_addr ^ MEM_BASE) >> MEM_AW) == 32'd0;
  assign hit_ledr   = io_page_hit(bus.lsu_addr, LEDR_BASE);
  assign hit_ledg   = io_page_hit(bus.lsu_addr, LEDG_BASE);
  assign hit_hex_lo = io_page_hit(bus.lsu_addr, HEX_LO_BASE);
  assign hit_hex_hi = io_page_hit(bus.lsu_addr, HEX_HI_BASE);
  assign hit_lcd    = io_page_hit(bus.lsu_addr, LCD_BASE);
  assign hit_sw     = io_page_hit(bus.lsu_addr, SW_BASE);
  assign hit_btn    = io_page_hit(bus.lsu_addr, BTN_BASE);
  assign hit_io     = hit_ledr | hit_ledg | hit_hex_lo | hit_hex_hi | hit_lcd | hit_sw | hit_btn;

  // IO accesses must be naturally aligned; memory tolerates any offset
  assign misalign = (size_mask[1] & off[0]) | (size_mask[3] & (off != 2'b00));
  assign io_ok    = hit_io & f3_valid & ~misalign;
  assign io_we    = i_reset & bus.lsu_wren & io_ok;
  assign lane_we  = size_mask << off;
  assign wdata_sh = bus.st_data << {off, 3'b000};

  // Memory port: lanes stay low-aligned, the memory applies the byte offset
  assign bus.mem_addr  = bus.lsu_addr[MEM_AW-1:0];
  assign bus.mem_wdata = bus.st_data;
  assign bus.mem_mask  = size_mask;
  assign bus.mem_wren  = i_reset & bus.lsu_wren & hit_mem & f3_valid;

  // IO register file: byte-lane writes, untouched lanes hold
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      ledr <= '0;
      ledg <= '0;
      lcd  <= '0;
      for (int i = 0; i < 8; i++) hex[i] <= HEX_BLANK;
    end else if (io_we) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_we[k]) begin
          if (hit_ledr)   ledr[8*k +: 8] <= wdata_sh[8*k +: 8];
          if (hit_ledg)   ledg[8*k +: 8] <= wdata_sh[8*k +: 8];
          if (hit_lcd)    lcd[8*k +: 8]  <= wdata_sh[8*k +: 8];
          if (hit_hex_lo) hex[k]         <= wdata_sh[8*k +: 7];
          if (hit_hex_hi) hex[k+4]       <= wdata_sh[8*k +: 7];
        end
      end
    end
  end

  // Rejected IO access is flagged for exactly the following cycle
  always_ff @(posedge i_clk) begin
    if (!i_reset) misaligned_q <= 1'b0;
    else          misaligned_q <= hit_io & f3_valid & misalign;
  end

  // Read-back word of the addressed IO register, then lane select and extend
  always_comb begin
    io_word = '0;
    if (hit_ledr)   io_word = ledr;
    if (hit_ledg)   io_word = ledg;
    if (hit_lcd)    io_word = lcd;
    if (hit_hex_lo) io_word = {1'b0, hex[3], 1'b0, hex[2], 1'b0, hex[1], 1'b0, hex[0]};
    if (hit_hex_hi) io_word = {1'b0, hex[7], 1'b0, hex[6], 1'b0, hex[5], 1'b0, hex[4]};
    if (hit_sw)     io_word = sw_sync;
    if (hit_btn)    io_word = {28'b0, btn_sync};
    ld_raw = '0;
    if (hit_mem)    ld_raw = bus.mem_rdata;
    else if (io_ok) ld_raw = io_word >> {off, 3'b000};
    bus.ld_data = f3_valid ? load_extend(ld_raw, bus.funct3) : '0;
  end

  assign bus.misaligned = misaligned_q;
  assign io_ledr = ledr;
  assign io_ledg = ledg;
  assign io_lcd  = lcd;
  assign io_hex0 = hex[0];
  assign io_hex1 = hex[1];
  assign io_hex2 = hex[2];
  assign io_hex3 = hex[3];
  assign io_hex4 = hex[4];
  assign io_hex5 = hex[5];
  assign io_hex6 = hex[6];
  assign io_hex7 = hex[7];

endmodule
